eight_req_prio_arbiter: RTL and testbench
=========================================

Name: eight_req_prio_arbiter

Overview:
Shares one downstream resource among 8 requesters using the team's 8-bit priority-encode ordering.
- Fixed mode: lowest set index wins.
- Round-robin mode: the search starts at a rotating pointer.
- A grant is held until the requester releases it or a hold limit expires. Handover to the next requester is back-to-back, with no idle cycle.
- Sits between requester blocks and the shared resource mux; grant_idx drives the mux select directly.

Parameters:
MAX_HOLD, 16, max consecutive cycles one grant may be held while others wait; 0 = unlimited
CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  8  request vector, bit i = requester i; held high for as long as access is needed
rr_en  input  1  1 = round-robin, 0 = fixed lowest-index priority; sampled only at arbitration edges
grant  output  8  one-hot grant, registered
grant_idx  output  3  binary index of the granted requester, registered
grant_vld  output  1  1 while any grant is active; always equals OR of grant

Behaviour:
- One clock; rst_n is asynchronous, active-low. Assertion clears all state immediately, without waiting for clk.
- Reset values: grant=0, grant_idx=0, grant_vld=0, ptr=0, hold_cnt=0, state=IDLE.
- Internal state: 1-bit state (IDLE/GRANT), 3-bit ptr, CNT_W-bit hold_cnt.

Winner selection over a candidate vector c:
- Fixed mode: lowest set index of c.
- RR mode: first set index scanning ptr, ptr+1, … 7, 0 … ptr-1 (mod 8).
- The same combinational function is used at every arbitration point.

IDLE:
- req==0: stay in IDLE; outputs stay 0.
- req!=0: at the next edge, winner w = select(req). Then grant=1<<w, grant_idx=w, grant_vld=1, hold_cnt=1, ptr=(w+1) mod 8, state=GRANT.
- Latency: req sampled at edge k; grant visible after edge k (1 cycle).

GRANT (holder h = grant_idx):
- Release (req[h]==0):
  - others = req with bit h cleared. If others!=0, re-arbitrate on others at this edge; the new grant takes effect at the next edge and hold_cnt=1.
  - If others==0: clear grant/grant_idx/grant_vld, hold_cnt=0, state=IDLE.
- Expiry (MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[h]==1):
  - Candidates = req with bit h cleared. If nonzero, re-arbitrate on them; the new winner is granted at the next edge and hold_cnt=1.
  - If candidates==0, h keeps the grant uninterrupted and hold_cnt restarts at 1.
- Otherwise: grant unchanged, hold_cnt increments. With MAX_HOLD=0 the counter saturates at its max value; it never wraps.

Pointer and mode:
- ptr updates on every new grant in both modes. It is only used when rr_en=1.
- A change of rr_en mid-grant has no effect until the next arbitration edge.

Invariants (checked by assertion):
- grant is zero or one-hot.
- grant_vld == |grant.
- grant[grant_idx] == grant_vld.
- The grant never moves without a release, an expiry, or reset.

Boundaries:
- Request arriving at the same edge as a release is eligible immediately.
- Release and expiry coincide: treat as release.
- ptr wraps 7→0.
- Glitches on non-holder req bits during GRANT are ignored.
- Reset mid-grant drops the grant asynchronously.

Test Plan:
1. Reset: grant active on idx 4, drive rst_n low between edges -> grant=0, grant_idx=0, grant_vld=0 before the next clk edge. After release, req=0 -> outputs stay 0.
2. Fixed mode: rr_en=0, req=8'b1010_0100 from reset -> one edge later grant=8'b0000_0100, grant_idx=2. Drop req[2] -> next edge grant_idx=5, then 7 after req[5] drops.
3. RR rotation: rr_en=1, MAX_HOLD=4, req=8'hFF held -> grant_idx 0,1,2,…,7,0, each held exactly 4 cycles, no idle cycle, ptr wrapping 7→0.
4. RR wrap on release: grant on idx 5 (ptr=6), req=8'b0000_0010, then req[5] drops -> next edge grant_idx=1 (scan order 6,7,0,1), ptr=2.
5. Sole-requester expiry: MAX_HOLD=4, req=8'b0000_1000 for 20 cycles -> grant_idx=3 continuously, grant_vld never drops, hold_cnt cycles 1..4.
6. Mode switch mid-grant: holder idx 6 in RR mode, set rr_en=0, req=8'b1100_0001, release 6 -> next grant idx 0 (fixed priority), not 7.

Source files
------------

// File: rtl/eight_req_prio_arbiter.sv
// Eight-way arbiter with fixed or round-robin priority and a bounded hold time.
// The grant stays with one requester until it releases or its hold limit runs out.
module eight_req_prio_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_vld
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    state_e           state_q, state_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       grant_idx_q, grant_idx_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [7:0] others;
    logic       holder_req;
    logic       expired;
    logic       arb;
    logic [2:0] win;

    // Scan starts at 'start' and wraps; start=0 gives plain lowest-index priority.
    function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (c[idx] && !found) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        holder_req = req[grant_idx_q];
        others     = req & ~grant_q;
        expired    = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C);
        arb        = 1'b0;
        state_d    = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    arb     = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    if (|others) arb = 1'b1;
                    else         state_d = IDLE;
                end else if (expired && |others) begin
                    arb = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign win = pick(others, rr_en ? ptr_q : 3'd0);

    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        if (arb) begin
            grant_d     = 8'b1 << win;
            grant_idx_d = win;
            ptr_d       = win + 3'd1;
            hold_cnt_d  = CNT_W'(1);
        end else if (state_q == GRANT && state_d == IDLE) begin
            grant_d     = '0;
            grant_idx_d = '0;
            hold_cnt_d  = '0;
        end else if (state_q == GRANT) begin
            // Sole requester at its limit keeps the grant with a fresh count.
            if (expired)                hold_cnt_d = CNT_W'(1);
            else if (hold_cnt_q != '1)  hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign grant_vld = |grant_q;

    a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        (grant_q == '0) || $onehot(grant_q));
    a_idx_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        grant_q[grant_idx_q] == grant_vld);
    a_grant_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == GRANT && holder_req && !expired) |=> $stable(grant_q));

endmodule

// File: tb/tb_eight_req_prio_arbiter.sv
// Scoreboard bench for eight_req_prio_arbiter: a behavioural model predicts each
// cycle's grant at drive time, and the prediction is compared after the edge.
module tb_eight_req_prio_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       vld;
        logic [4:0] cnt;
        logic [2:0] ptr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int m_vld, m_idx, m_cnt, m_ptr;

    eight_req_prio_arbiter #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_en     (rr_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int pick_m(input logic [7:0] c, input int start);
        for (int k = 0; k < 8; k++) begin
            if (c[(start + k) % 8]) return (start + k) % 8;
        end
        return 0;
    endfunction

    task automatic grant_to(input int w);
        m_vld = 1;
        m_idx = w;
        m_cnt = 1;
        m_ptr = (w + 1) % 8;
    endtask

    task automatic model_reset();
        m_vld = 0; m_idx = 0; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rr);
        logic [7:0] others;
        int         start;
        start = rr ? m_ptr : 0;
        if (m_vld == 0) begin
            if (r != 0) grant_to(pick_m(r, start));
        end else begin
            others        = r;
            others[m_idx] = 1'b0;
            if (!r[m_idx]) begin
                if (others != 0) grant_to(pick_m(others, start));
                else begin m_vld = 0; m_idx = 0; m_cnt = 0; end
            end else if (MAXH != 0 && m_cnt == MAXH) begin
                if (others != 0) grant_to(pick_m(others, start));
                else m_cnt = 1;
            end else if (m_cnt < 31) begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rr);
        exp_t e;
        @(negedge clk);
        req   = r;
        rr_en = rr;
        model_step(r, rr);
        e.grant = (m_vld != 0) ? (8'b1 << m_idx) : 8'b0;
        e.idx   = 3'(m_idx);
        e.vld   = (m_vld != 0);
        e.cnt   = 5'(m_cnt);
        e.ptr   = 3'(m_ptr);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("grant_idx", 32'(grant_idx), 32'(e.idx));
        check("grant_vld", 32'(grant_vld), 32'(e.vld));
        check("hold_cnt", 32'(dut.hold_cnt_q), 32'(e.cnt));
        check("ptr", 32'(dut.ptr_q), 32'(e.ptr));
    endtask

    initial begin
        int last, run;
        rst_n = 1'b0;
        req   = '0;
        rr_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_vld", 32'(grant_vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed priority: lowest index first, handover on release.
        step(8'b1010_0100, 1'b0);
        check("fix_first", 32'(grant), 32'h04);
        step(8'b1010_0000, 1'b0);
        check("fix_second", 32'(grant_idx), 32'd5);
        step(8'b1000_0000, 1'b0);
        check("fix_third", 32'(grant_idx), 32'd7);
        step(8'h00, 1'b0);

        // Asynchronous reset while idx 4 holds the grant.
        step(8'h10, 1'b0);
        check("pre_rst_idx", 32'(grant_idx), 32'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'h0);
        check("async_idx", 32'(grant_idx), 32'h0);
        check("async_vld", 32'(grant_vld), 32'h0);
        model_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        repeat (3) step(8'h00, 1'b0);

        // Round-robin rotation with everyone requesting.
        last = -1;
        run  = 0;
        for (int i = 0; i < 40; i++) begin
            step(8'hFF, 1'b1);
            check("rr_vld", 32'(grant_vld), 32'd1);
            if (int'(grant_idx) == last) run++;
            else begin
                if (last >= 0) begin
                    check("rr_run", 32'(run), 32'd4);
                    check("rr_next", 32'(grant_idx), 32'((last + 1) % 8));
                end
                last = int'(grant_idx);
                run  = 1;
            end
        end
        step(8'h00, 1'b1);

        // Round-robin scan wraps past 7 on release.
        step(8'b0010_0000, 1'b1);
        check("wrap_hold", 32'(grant_idx), 32'd5);
        step(8'b0010_0010, 1'b1);
        step(8'b0000_0010, 1'b1);
        check("wrap_idx", 32'(grant_idx), 32'd1);
        check("wrap_ptr", 32'(dut.ptr_q), 32'd2);
        step(8'h00, 1'b1);

        // Sole requester keeps the grant across expiry.
        for (int i = 0; i < 20; i++) begin
            step(8'b0000_1000, 1'b1);
            check("sole_idx", 32'(grant_idx), 32'd3);
        end
        step(8'h00, 1'b1);

        // Mode change mid-grant only matters at the next arbitration.
        step(8'h40, 1'b1);
        step(8'b1100_0001, 1'b0);
        check("mode_hold", 32'(grant_idx), 32'd6);
        step(8'b1000_0001, 1'b0);
        check("mode_fixed", 32'(grant_idx), 32'd0);
        step(8'h00, 1'b0);

        // Release coinciding with expiry is a release.
        repeat (4) step(8'h08, 1'b0);
        check("coincide_cnt", 32'(dut.hold_cnt_q), 32'd4);
        step(8'h00, 1'b0);
        check("coincide_vld", 32'(grant_vld), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
